n64_vinfo_ext: RTL and testbench
================================

# n64_vinfo_ext

Video-info extraction stage sitting directly upstream of the video demultiplexer. It watches the raw N64 video bus (nDSYNC and the sync nibble on D_i[3:0]) and generates the per-pixel data phase counter, PAL/NTSC mode, interlace detection and the packed 5-bit demux parameter word that the demux stage consumes. All state updates are qualified by nDSYNC, so outputs follow the N64 four-cycle pixel cadence.

## Interface
Parameters:
- LINE_CNT_W, 9, width of the per-field line counter (saturating).
- PAL_THRESH, 288, line count above which a field is classified PAL.

Ports:
- VCLK  in  1  video clock; the only clock.
- RST  in  1  reset; synchronous, active-high.
- nDSYNC  in  1  low marks the sync-nibble cycle of each pixel.
- D_i  in  7  N64 data bus; sync nibble on D_i[3:0] = {nVSYNC, nCLAMP, nHSYNC, nCSYNC} when nDSYNC low.
- deblur_en_i  in  1  user request for deblur (1 = allow deblur).
- n15bit_i  in  1  1 = full 21-bit colour, 0 = 15-bit reduction.
- demuxparams_o  out  5  {data_cnt[1:0], vmode, ndo_deblur, n15bit_mode}.
- vinfo_o  out  3  {FrameID, n64_480i, vmode} for status/OSD use.

## Operation
- Sync sampling: on every VCLK with nDSYNC low, sync_prev <= D_i[3:0]. Edges are detected in the same cycle: negedge_vs = sync_prev[3] & !D_i[3]; posedge_hs = !sync_prev[1] & D_i[1]. No edges are evaluated when nDSYNC is high.
- data_cnt: nDSYNC low -> 2'b01; otherwise data_cnt + 1 (2-bit wrap). Yields sequence 01,10,11,00 for R,G,B,sync slots.
- Line counter: increments on posedge_hs, saturates at 2^LINE_CNT_W-1 (511).
- On negedge_vs (field end):
  - field_len = line_cnt + posedge_hs (a simultaneous HSYNC edge belongs to the finished field; saturate).
  - line_cnt <= 0.
  - cand = (field_len > PAL_THRESH). vmode <= cand only if cand == cand_prev; cand_prev <= cand. Two consecutive agreeing fields are required to change vmode.
  - FrameID <= D_i[1] (nHSYNC level at VSYNC fall); n64_480i <= (D_i[1] != FrameID).
- Combinational packing from registers: ndo_deblur = n64_480i | !deblur_en_i; n15bit_mode = n15bit_i.
- Reset (RST high at a VCLK edge) overrides everything: data_cnt 0, sync_prev 4'hF, line_cnt 0, cand_prev 0, vmode 0 (NTSC), FrameID 0, n64_480i 0. After reset, demuxparams_o = {2'b00, 0, !deblur_en_i, n15bit_i}.

## Timing
- All registered outputs update at the VCLK edge that samples the event; visible in the following cycle (latency 1).
- data_cnt reads 01 in the cycle after the nDSYNC-low cycle.
- vmode changes at earliest at the end of the second field classified differently.
- n64_480i valid from the second VSYNC fall after reset.
- RST mid-field: field is discarded; next field starts from line_cnt 0 only after the first VSYNC fall after reset (the partial field before it is counted but its classification only seeds cand_prev).
- deblur_en_i / n15bit_i propagate combinationally; the consumer samples them on its own cadence.

## Structure
- Shared header vh/n64rgb_params.vh holds PAL_THRESH, LINE_CNT_W and demuxparams bit positions (data_cnt [4:3], vmode [2], ndo_deblur [1], n15bit_mode [0]); the demux stage uses the same positions.
- One sub-module natural: n64_field_meas (line counter, field-end classification, two-field vmode filter, FrameID/480i detection); top keeps sync sampling, data_cnt and packing.

## Test plan
- Reset then pixel stream nDSYNC low 1 in 4 -> data_cnt 01,10,11,00 repeating; demuxparams_o[4:3] matches.
- Two fields of 262 HSYNC rising edges -> vmode 0, vinfo_o[0] 0 throughout.
- Fields of 312 lines after NTSC: first PAL field -> vmode stays 0; second -> vmode 1 one cycle after VSYNC fall.
- nHSYNC level at VSYNC fall alternating 0/1 -> n64_480i 1, ndo_deblur 1 even with deblur_en_i 1; constant level -> n64_480i 0, ndo_deblur = !deblur_en_i.
- HSYNC rise and VSYNC fall in the same sync sample with line_cnt 288 -> field_len 289, classified PAL; line_cnt 0 afterwards.
- 600 HSYNC edges without VSYNC -> line_cnt saturates 511; RST asserted mid-field -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/n64_vinfo_ext_pkg.sv
// Shared constants for the N64 video-info extraction stage.
// Demux parameter bit positions are shared with the downstream demux stage.
package n64_vinfo_ext_pkg;

  localparam int DEF_LINE_CNT_W = 9;
  localparam int DEF_PAL_THRESH = 288;

  // demuxparams word layout: {data_cnt[1:0], vmode, ndo_deblur, n15bit_mode}
  localparam int DMX_DATA_CNT_HI = 4;
  localparam int DMX_DATA_CNT_LO = 3;
  localparam int DMX_VMODE       = 2;
  localparam int DMX_NDO_DEBLUR  = 1;
  localparam int DMX_N15BIT      = 0;

  // Sync nibble {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
  localparam int         SYNC_NVSYNC = 3;
  localparam int         SYNC_NHSYNC = 1;
  localparam logic [3:0] SYNC_IDLE   = 4'hF;

  typedef struct packed {
    logic frame_id;
    logic n64_480i;
    logic vmode;
  } vinfo_t;

endpackage

// File: rtl/n64_field_meas.sv
// Per-field line counting, PAL/NTSC classification with two-field filter,
// and FrameID / 480i detection from the nHSYNC level at VSYNC fall.
module n64_field_meas
  import n64_vinfo_ext_pkg::*;
#(
  parameter int LINE_CNT_W = DEF_LINE_CNT_W,
  parameter int PAL_THRESH = DEF_PAL_THRESH
) (
  input  logic clk,
  input  logic rst,
  input  logic posedge_hs,
  input  logic negedge_vs,
  input  logic nhsync,
  output logic vmode,
  output logic frame_id,
  output logic n64_480i
);

  localparam logic [LINE_CNT_W-1:0] LINE_MAX = '1;
  localparam logic [LINE_CNT_W-1:0] THRESH   = LINE_CNT_W'(PAL_THRESH);

  logic [LINE_CNT_W-1:0] line_cnt;
  logic [LINE_CNT_W-1:0] field_len;
  logic                  cand;
  logic                  cand_prev;

  // An HSYNC edge coinciding with VSYNC fall still belongs to the ending field.
  always_comb begin
    field_len = line_cnt;
    if (posedge_hs && (line_cnt != LINE_MAX))
      field_len = line_cnt + 1'b1;
    cand = (field_len > THRESH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt  <= '0;
      cand_prev <= 1'b0;
      vmode     <= 1'b0;
      frame_id  <= 1'b0;
      n64_480i  <= 1'b0;
    end else if (negedge_vs) begin
      line_cnt  <= '0;
      cand_prev <= cand;
      if (cand == cand_prev)
        vmode <= cand;
      frame_id <= nhsync;
      n64_480i <= (nhsync != frame_id);
    end else if (posedge_hs && (line_cnt != LINE_MAX)) begin
      line_cnt <= line_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/n64_vinfo_ext.sv
// Video-info extraction ahead of the demux: sync sampling, pixel phase
// counter and packing of the demux parameter word.
module n64_vinfo_ext
  import n64_vinfo_ext_pkg::*;
#(
  parameter int LINE_CNT_W = DEF_LINE_CNT_W,
  parameter int PAL_THRESH = DEF_PAL_THRESH
) (
  input  logic       VCLK,
  input  logic       RST,
  input  logic       nDSYNC,
  input  logic [6:0] D_i,
  input  logic       deblur_en_i,
  input  logic       n15bit_i,
  output logic [4:0] demuxparams_o,
  output logic [2:0] vinfo_o
);

  logic [1:0] data_cnt;
  logic [3:0] sync_prev;
  logic       negedge_vs;
  logic       posedge_hs;
  vinfo_t     vinfo;
  logic       unused_bits;

  // Edges only exist on sync-nibble cycles; colour data never looks like sync.
  assign negedge_vs = !nDSYNC &  sync_prev[SYNC_NVSYNC] & !D_i[SYNC_NVSYNC];
  assign posedge_hs = !nDSYNC & !sync_prev[SYNC_NHSYNC] &  D_i[SYNC_NHSYNC];

  assign unused_bits = ^{D_i[6:4], D_i[2], D_i[0], sync_prev[2], sync_prev[0]};

  always_ff @(posedge VCLK) begin
    if (RST) begin
      data_cnt  <= 2'b00;
      sync_prev <= SYNC_IDLE;
    end else if (!nDSYNC) begin
      data_cnt  <= 2'b01;
      sync_prev <= D_i[3:0];
    end else begin
      data_cnt  <= data_cnt + 2'b01;
    end
  end

  n64_field_meas #(
    .LINE_CNT_W (LINE_CNT_W),
    .PAL_THRESH (PAL_THRESH)
  ) u_meas (
    .clk        (VCLK),
    .rst        (RST),
    .posedge_hs (posedge_hs),
    .negedge_vs (negedge_vs),
    .nhsync     (D_i[SYNC_NHSYNC]),
    .vmode      (vinfo.vmode),
    .frame_id   (vinfo.frame_id),
    .n64_480i   (vinfo.n64_480i)
  );

  always_comb begin
    demuxparams_o                                   = '0;
    demuxparams_o[DMX_DATA_CNT_HI:DMX_DATA_CNT_LO] = data_cnt;
    demuxparams_o[DMX_VMODE]                        = vinfo.vmode;
    demuxparams_o[DMX_NDO_DEBLUR]                   = vinfo.n64_480i | !deblur_en_i;
    demuxparams_o[DMX_N15BIT]                       = n15bit_i;
  end

  assign vinfo_o = vinfo;

endmodule

// File: tb/tb_n64_vinfo_ext.sv
// Directed self-checking bench for n64_vinfo_ext.
module tb_n64_vinfo_ext;

  logic       VCLK = 1'b0;
  logic       RST;
  logic       nDSYNC;
  logic [6:0] D_i;
  logic       deblur_en_i;
  logic       n15bit_i;
  logic [4:0] demuxparams_o;
  logic [2:0] vinfo_o;

  int checks = 0;
  int passed = 0;
  logic [2:0] vinfo_fall;
  logic [4:0] demux_fall;

  n64_vinfo_ext dut (
    .VCLK          (VCLK),
    .RST           (RST),
    .nDSYNC        (nDSYNC),
    .D_i           (D_i),
    .deblur_en_i   (deblur_en_i),
    .n15bit_i      (n15bit_i),
    .demuxparams_o (demuxparams_o),
    .vinfo_o       (vinfo_o)
  );

  always #5 VCLK = ~VCLK;

  task automatic data_cycles();
    for (int i = 0; i < 3; i++) begin
      nDSYNC = 1'b1;
      D_i    = 7'($urandom);
      @(negedge VCLK);
    end
  endtask

  task automatic pixel(input logic [3:0] nib);
    nDSYNC = 1'b0;
    D_i    = {3'b000, nib};
    @(negedge VCLK);
    data_cycles();
  endtask

  task automatic vs_fall(input logic fl);
    nDSYNC = 1'b0;
    D_i    = {3'b000, 1'b0, 1'b1, fl, 1'b1};
    @(negedge VCLK);
    vinfo_fall = vinfo_o;
    demux_fall = demuxparams_o;
    data_cycles();
    pixel({1'b1, 1'b1, fl, 1'b1});
  endtask

  task automatic field(input int n, input logic fl, input logic sim);
    for (int l = 0; l < n; l++) begin
      pixel(4'b1101);
      pixel(4'b1111);
    end
    if (sim) pixel(4'b1101);
    vs_fall(fl);
  endtask

  task automatic test_reset();
    RST = 1'b1; nDSYNC = 1'b1; D_i = 7'h0F; deblur_en_i = 1'b1; n15bit_i = 1'b1;
    repeat (3) @(negedge VCLK);
    checks++;
    if (demuxparams_o !== 5'b00001) $display("FAIL reset_demux: got %b expected %b", demuxparams_o, 5'b00001);
    else passed++;
    checks++;
    if (vinfo_o !== 3'b000) $display("FAIL reset_vinfo: got %b expected %b", vinfo_o, 3'b000);
    else passed++;
    deblur_en_i = 1'b0; n15bit_i = 1'b0; #1;
    checks++;
    if (demuxparams_o !== 5'b00010) $display("FAIL reset_comb_pack: got %b expected %b", demuxparams_o, 5'b00010);
    else passed++;
    deblur_en_i = 1'b1; n15bit_i = 1'b1;
    @(negedge VCLK);
    RST = 1'b0;
  endtask

  task automatic test_data_cnt();
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b11; exp_seq[3] = 2'b00;
    for (int p = 0; p < 3; p++) begin
      nDSYNC = 1'b0;
      D_i    = 7'h0F;
      for (int c = 0; c < 4; c++) begin
        @(negedge VCLK);
        checks++;
        if (demuxparams_o[4:3] !== exp_seq[c])
          $display("FAIL data_cnt p%0d c%0d: got %b expected %b", p, c, demuxparams_o[4:3], exp_seq[c]);
        else passed++;
        nDSYNC = 1'b1;
        D_i    = 7'($urandom);
      end
    end
  endtask

  task automatic test_ntsc();
    for (int f = 0; f < 2; f++) begin
      field(262, 1'b0, 1'b0);
      checks++;
      if (vinfo_fall !== 3'b000) $display("FAIL ntsc_field%0d: got %b expected %b", f, vinfo_fall, 3'b000);
      else passed++;
    end
  endtask

  task automatic test_pal();
    field(312, 1'b0, 1'b0);
    checks++;
    if (vinfo_fall !== 3'b000) $display("FAIL pal_first_field: got %b expected %b", vinfo_fall, 3'b000);
    else passed++;
    field(312, 1'b0, 1'b0);
    checks++;
    if (vinfo_fall !== 3'b001) $display("FAIL pal_second_field: got %b expected %b", vinfo_fall, 3'b001);
    else passed++;
  endtask

  task automatic test_interlace();
    field(312, 1'b1, 1'b0);
    checks++;
    if (vinfo_fall !== 3'b111) $display("FAIL ilace_f1_vinfo: got %b expected %b", vinfo_fall, 3'b111);
    else passed++;
    checks++;
    if (demux_fall !== 5'b01111) $display("FAIL ilace_f1_demux: got %b expected %b", demux_fall, 5'b01111);
    else passed++;
    field(312, 1'b0, 1'b0);
    checks++;
    if (vinfo_fall !== 3'b011) $display("FAIL ilace_f2_vinfo: got %b expected %b", vinfo_fall, 3'b011);
    else passed++;
    field(312, 1'b0, 1'b0);
    checks++;
    if (vinfo_fall !== 3'b001) $display("FAIL prog_vinfo: got %b expected %b", vinfo_fall, 3'b001);
    else passed++;
    checks++;
    if (demux_fall !== 5'b01101) $display("FAIL prog_demux: got %b expected %b", demux_fall, 5'b01101);
    else passed++;
    deblur_en_i = 1'b0; #1;
    checks++;
    if (demuxparams_o[1] !== 1'b1) $display("FAIL prog_ndo_deblur_off: got %b expected %b", demuxparams_o[1], 1'b1);
    else passed++;
    deblur_en_i = 1'b1; #1;
    checks++;
    if (demuxparams_o[1] !== 1'b0) $display("FAIL prog_ndo_deblur_on: got %b expected %b", demuxparams_o[1], 1'b0);
    else passed++;
  endtask

  task automatic test_boundary();
    field(288, 1'b0, 1'b0);
    checks++;
    if (vinfo_fall !== 3'b001) $display("FAIL b288_first: got %b expected %b", vinfo_fall, 3'b001);
    else passed++;
    field(288, 1'b0, 1'b0);
    checks++;
    if (vinfo_fall !== 3'b000) $display("FAIL b288_second: got %b expected %b", vinfo_fall, 3'b000);
    else passed++;
    field(288, 1'b1, 1'b1);
    checks++;
    if (vinfo_fall !== 3'b110) $display("FAIL b289_first: got %b expected %b", vinfo_fall, 3'b110);
    else passed++;
    checks++;
    if (dut.u_meas.line_cnt !== 9'd0) $display("FAIL b289_line_cnt_clear: got %0d expected %0d", dut.u_meas.line_cnt, 0);
    else passed++;
    field(288, 1'b1, 1'b1);
    checks++;
    if (vinfo_fall !== 3'b101) $display("FAIL b289_second: got %b expected %b", vinfo_fall, 3'b101);
    else passed++;
  endtask

  task automatic test_saturate_reset();
    for (int l = 0; l < 600; l++) begin
      pixel(4'b1101);
      pixel(4'b1111);
    end
    checks++;
    if (dut.u_meas.line_cnt !== 9'd511) $display("FAIL line_cnt_sat: got %0d expected %0d", dut.u_meas.line_cnt, 511);
    else passed++;
    RST = 1'b1; nDSYNC = 1'b1; D_i = 7'h2A;
    @(negedge VCLK);
    checks++;
    if (demuxparams_o !== 5'b00001) $display("FAIL midreset_demux: got %b expected %b", demuxparams_o, 5'b00001);
    else passed++;
    checks++;
    if (vinfo_o !== 3'b000) $display("FAIL midreset_vinfo: got %b expected %b", vinfo_o, 3'b000);
    else passed++;
    checks++;
    if (dut.u_meas.line_cnt !== 9'd0) $display("FAIL midreset_line_cnt: got %0d expected %0d", dut.u_meas.line_cnt, 0);
    else passed++;
    RST = 1'b0;
    field(312, 1'b0, 1'b0);
    checks++;
    if (vinfo_fall !== 3'b000) $display("FAIL post_reset_seed: got %b expected %b", vinfo_fall, 3'b000);
    else passed++;
    field(312, 1'b0, 1'b0);
    checks++;
    if (vinfo_fall !== 3'b001) $display("FAIL post_reset_pal: got %b expected %b", vinfo_fall, 3'b001);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_data_cnt();
    test_ntsc();
    test_pal();
    test_interlace();
    test_boundary();
    test_saturate_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
